csi2tx_pred_sequencer: RTL and testbench
========================================

Name: csi2tx_pred_sequencer

Overview:
Control block that sequences the CSI-2 TX DPCM predictor across each image line.
- Accepts a raw pixel stream with a valid/ready handshake and latches the compression scheme per frame.
- Tracks pixel position within the line and generates the predictor's enable and pixel1..pixel4 position strobes.
- Flags malformed lines.
- Sits between the pixel2byte input FIFO and the predictor/encoder pair, in the sensor_clk domain.

Parameters:
LEN_W, 16, width of line length and pixel counter
SCHEME_W, 5, width of comp_scheme (fixed by csi2tx_defines.v encoding)

Ports:
sensor_clk  in  1  single clock; all logic is rising-edge
sys_rst_n  in  1  asynchronous active-low reset
comp_scheme_in  in  SCHEME_W  requested scheme; bit3 selects predictor1; all-zero means no compression
line_len  in  LEN_W  pixels per line; sampled at line_start
frame_start  in  1  one-cycle frame start pulse
line_start  in  1  one-cycle line start pulse
line_end  in  1  one-cycle line end pulse from source
pix_valid  in  1  source pixel valid
pix_ready  out  1  sequencer can accept a pixel
out_ready  in  1  encoder can accept a pixel
comp_scheme  out  SCHEME_W  frame-latched scheme driven to the predictor
enable  out  1  predictor advance; high only in a pixel-transfer cycle
pixel1_valid  out  1  transferred pixel is the 1st of its line
pixel2_valid  out  1  transferred pixel is the 2nd of its line
pixel3_valid  out  1  transferred pixel is the 3rd of its line
pixel4_valid  out  1  transferred pixel is the 4th of its line
line_done  out  1  registered pulse after the last pixel of a line is transferred
line_err  out  1  registered pulse on short or aborted line, or zero line_len

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; comp_scheme 0.
- FSM states:
  - IDLE: waits for frame_start.
  - WAIT_LINE: waits for line_start.
  - ACTIVE: transfers pixels.
- Transitions:
  - frame_start in any state: latch comp_scheme <= comp_scheme_in. If in ACTIVE, pulse line_err and abort the line. Next state is WAIT_LINE.
  - frame_start and line_start in the same cycle: both are honoured; next state is ACTIVE.
  - line_start in WAIT_LINE: sample line_len into len_q, clear pix_cnt and pos, go ACTIVE. If line_len==0, pulse line_err and stay in WAIT_LINE.
- comp_scheme does not change at any time other than frame_start.
- Transfer in ACTIVE:
  - pix_ready = out_ready when state==ACTIVE, else 0.
  - xfer = pix_valid & pix_ready.
- Strobes (combinational from registered state and xfer; zero latency, aligned with the transferred pixel):
  - enable = xfer & (|comp_scheme).
  - pixelN_valid = enable & (pos==N-1).
  - pos increments on each xfer and saturates at 4. From the 5th pixel on, no pixelN strobe is active, so the predictor applies its full 4-tap rule.
- Line completion: on xfer with pix_cnt==len_q-1, pulse line_done next cycle and go to WAIT_LINE. pix_cnt wraps to 0.
- Early termination in ACTIVE:
  - line_end or line_start before completion: pulse line_err.
  - line_start then restarts the line in the same cycle (re-sample line_len, clear counters, stay ACTIVE).
  - line_end alone goes to WAIT_LINE.
- line_end coincident with the completing xfer: treated as a normal completion, no error.
- Uncompressed frame (comp_scheme==0): the handshake and line tracking still operate. enable and all pixelN_valid stay 0.
- out_ready low stalls: counters and strobes hold, and no pixel is lost.
- Reset mid-line: immediate return to IDLE with all outputs 0; the line is not reported.

Decomposition:
- Add to csi2tx_defines.v:
  - FSM state encodings (IDLE, WAIT_LINE, ACTIVE).
  - Predictor-select bit index (3).
  - Saturation constant for pos (4).
- One natural sub-module: csi2tx_line_counter, holding len_q, pix_cnt and the last-pixel compare.
- FSM, scheme latch and strobe decode remain in the top module.

Test Plan:
- Scheme 0x08 (bit3 set), frame_start, line_start with line_len=6, 6 back-to-back pixels -> enable high 6 cycles; pixel1..4_valid each exactly once, on transfers 1..4; line_done 1 cycle after the 6th pixel.
- line_len=6, out_ready toggled 1/0 every cycle -> pix_ready mirrors out_ready; pos and strobes hold during stalls; 6 transfers then line_done; no line_err.
- line_len=8, line_end after 3 transfers -> line_err pulse; state WAIT_LINE; next line_start restarts with pixel1_valid on the first transfer.
- comp_scheme_in changed from 0x08 to 0x02 mid-line -> comp_scheme stays 0x08 until the next frame_start, then becomes 0x02.
- comp_scheme_in=0, line_len=4 -> 4 transfers and line_done; enable and pixel1..4_valid never asserted.
- sys_rst_n low after 2 transfers -> all outputs 0 asynchronously; after release, state IDLE; line_start ignored until frame_start.

Source files
------------

// File: rtl/csi2tx_pred_sequencer_pkg.sv
// Shared types and constants for the CSI-2 TX DPCM predictor sequencer.
package csi2tx_pred_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_ACTIVE    = 2'd2
  } seq_state_t;

  localparam int          POS_W   = 3;
  // pos stops here so the predictor falls back to its full 4-tap rule
  localparam logic [2:0]  POS_SAT = 3'd4;

endpackage

// File: rtl/csi2tx_pred_sequencer_if.sv
// Pixel handshake plus predictor-facing strobes between source, sequencer and predictor.
interface csi2tx_pred_sequencer_if #(
  parameter int SCHEME_W = 5
);
  logic                pix_valid;
  logic                pix_ready;
  logic                out_ready;
  logic [SCHEME_W-1:0] comp_scheme;
  logic                enable;
  logic                pixel1_valid;
  logic                pixel2_valid;
  logic                pixel3_valid;
  logic                pixel4_valid;

  modport master (
    output pix_valid, out_ready,
    input  pix_ready, comp_scheme, enable,
           pixel1_valid, pixel2_valid, pixel3_valid, pixel4_valid
  );

  modport slave (
    input  pix_valid, out_ready,
    output pix_ready, comp_scheme, enable,
           pixel1_valid, pixel2_valid, pixel3_valid, pixel4_valid
  );
endinterface

// File: rtl/csi2tx_line_counter.sv
// Line length register and pixel counter; flags the last pixel of the current line.
module csi2tx_line_counter #(
  parameter int LEN_W = 16
) (
  input  logic             sensor_clk,
  input  logic             sys_rst_n,
  input  logic             load,
  input  logic             adv,
  input  logic [LEN_W-1:0] line_len,
  output logic             last
);

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pix_cnt;

  assign last = (pix_cnt == len_q - LEN_W'(1));

  always_ff @(posedge sensor_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      len_q   <= '0;
      pix_cnt <= '0;
    end else if (load) begin
      len_q   <= line_len;
      pix_cnt <= '0;
    end else if (adv) begin
      pix_cnt <= last ? '0 : pix_cnt + LEN_W'(1);
    end
  end

endmodule

// File: rtl/csi2tx_pred_sequencer.sv
// Sequences the DPCM predictor across each line: handshake, position strobes, line status.
import csi2tx_pred_sequencer_pkg::*;

module csi2tx_pred_sequencer #(
  parameter int LEN_W    = 16,
  parameter int SCHEME_W = 5
) (
  input  logic                sensor_clk,
  input  logic                sys_rst_n,
  input  logic [SCHEME_W-1:0] comp_scheme_in,
  input  logic [LEN_W-1:0]    line_len,
  input  logic                frame_start,
  input  logic                line_start,
  input  logic                line_end,
  output logic                line_done,
  output logic                line_err,
  csi2tx_pred_sequencer_if.slave bus
);

  seq_state_t          state;
  logic [SCHEME_W-1:0] scheme_q;
  logic [POS_W-1:0]    pos;
  logic                active;
  logic                xfer;
  logic                last;
  logic                done;
  logic                start_ok;
  logic                len_zero;
  logic                load;
  logic                abort_err;

  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
    return (p >= POS_SAT) ? POS_SAT : p + POS_W'(1);
  endfunction

  assign active        = (state == ST_ACTIVE);
  assign bus.pix_ready = active & bus.out_ready;
  assign xfer          = bus.pix_valid & bus.pix_ready;
  assign done          = xfer & last;

  // line_start is only meaningful once a frame has begun (or begins this cycle)
  assign start_ok  = line_start & (frame_start | (state != ST_IDLE));
  assign len_zero  = (line_len == '0);
  assign load      = start_ok & ~len_zero;
  assign abort_err = active & ~done & (frame_start | line_start | line_end);

  assign bus.comp_scheme  = scheme_q;
  assign bus.enable       = xfer & (|scheme_q);
  assign bus.pixel1_valid = bus.enable & (pos == POS_W'(0));
  assign bus.pixel2_valid = bus.enable & (pos == POS_W'(1));
  assign bus.pixel3_valid = bus.enable & (pos == POS_W'(2));
  assign bus.pixel4_valid = bus.enable & (pos == POS_W'(3));

  csi2tx_line_counter #(.LEN_W(LEN_W)) u_line_counter (
    .sensor_clk (sensor_clk),
    .sys_rst_n  (sys_rst_n),
    .load       (load),
    .adv        (xfer),
    .line_len   (line_len),
    .last       (last)
  );

  always_ff @(posedge sensor_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      scheme_q  <= '0;
      pos       <= '0;
      line_done <= 1'b0;
      line_err  <= 1'b0;
    end else begin
      line_done <= done;
      line_err  <= abort_err | (start_ok & len_zero);

      if (frame_start) scheme_q <= comp_scheme_in;

      if (load)      pos <= '0;
      else if (xfer) pos <= pos_inc(pos);

      // a restart wins over every reason to leave the line
      if (load)
        state <= ST_ACTIVE;
      else if (frame_start | start_ok | done | (active & line_end))
        state <= ST_WAIT_LINE;
    end
  end

endmodule

// File: tb/tb_csi2tx_pred_sequencer.sv
// Directed bench for csi2tx_pred_sequencer with a per-cycle line-level reference model.
`timescale 1ns/1ps
module tb_csi2tx_pred_sequencer;

  localparam int LEN_W    = 16;
  localparam int SCHEME_W = 5;
  localparam int M_IDLE = 0, M_WAIT = 1, M_ACTIVE = 2;

  logic                sensor_clk = 1'b0;
  logic                sys_rst_n  = 1'b0;
  logic [SCHEME_W-1:0] comp_scheme_in = '0;
  logic [LEN_W-1:0]    line_len = '0;
  logic                frame_start = 1'b0;
  logic                line_start  = 1'b0;
  logic                line_end    = 1'b0;
  logic                line_done;
  logic                line_err;

  csi2tx_pred_sequencer_if #(.SCHEME_W(SCHEME_W)) bus ();

  csi2tx_pred_sequencer #(.LEN_W(LEN_W), .SCHEME_W(SCHEME_W)) dut (
    .sensor_clk     (sensor_clk),
    .sys_rst_n      (sys_rst_n),
    .comp_scheme_in (comp_scheme_in),
    .line_len       (line_len),
    .frame_start    (frame_start),
    .line_start     (line_start),
    .line_end       (line_end),
    .line_done      (line_done),
    .line_err       (line_err),
    .bus            (bus)
  );

  always #5 sensor_clk = ~sensor_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: line mode, latched scheme, line length, pixels moved so far
  int m_state = M_IDLE, m_scheme = 0, m_len = 0, m_idx = 0;
  int e_done = 0, e_err = 0;

  // Observation counters for the literal expectations
  int c_xfer, c_en, c_done, c_err;
  int c_p[4];
  int at_p[4];

  task automatic clr_counts();
    c_xfer = 0; c_en = 0; c_done = 0; c_err = 0;
    for (int i = 0; i < 4; i++) begin c_p[i] = 0; at_p[i] = 0; end
  endtask

  always @(negedge sensor_clk) begin
    bit m_xfer, complete, n_err;
    int nxt, e_en;
    int pv[4];
    if (!sys_rst_n) begin
      m_state = M_IDLE; m_scheme = 0; m_len = 0; m_idx = 0; e_done = 0; e_err = 0;
    end
    m_xfer = (m_state == M_ACTIVE) && bus.out_ready && bus.pix_valid;
    e_en   = (m_xfer && m_scheme != 0) ? 1 : 0;
    for (int i = 0; i < 4; i++) pv[i] = (e_en == 1 && m_idx == i) ? 1 : 0;

    chk("pix_ready",   int'(bus.pix_ready), int'((m_state == M_ACTIVE) && bus.out_ready));
    chk("enable",      int'(bus.enable), e_en);
    chk("pixel1",      int'(bus.pixel1_valid), pv[0]);
    chk("pixel2",      int'(bus.pixel2_valid), pv[1]);
    chk("pixel3",      int'(bus.pixel3_valid), pv[2]);
    chk("pixel4",      int'(bus.pixel4_valid), pv[3]);
    chk("comp_scheme", int'(bus.comp_scheme), m_scheme);
    chk("line_done",   int'(line_done), e_done);
    chk("line_err",    int'(line_err), e_err);

    if (bus.pix_valid && bus.pix_ready) c_xfer++;
    if (bus.enable) c_en++;
    if (line_done)  c_done++;
    if (line_err)   c_err++;
    if (bus.pixel1_valid) begin c_p[0]++; at_p[0] = c_xfer; end
    if (bus.pixel2_valid) begin c_p[1]++; at_p[1] = c_xfer; end
    if (bus.pixel3_valid) begin c_p[2]++; at_p[2] = c_xfer; end
    if (bus.pixel4_valid) begin c_p[3]++; at_p[3] = c_xfer; end

    if (sys_rst_n) begin
      complete = m_xfer && (m_idx + 1 == m_len);
      n_err    = (m_state == M_ACTIVE) && !complete && (frame_start || line_start || line_end);
      if (m_xfer) m_idx++;
      nxt = m_state;
      if (complete || (m_state == M_ACTIVE && line_end) || frame_start) nxt = M_WAIT;
      if (frame_start) m_scheme = int'(comp_scheme_in);
      if (line_start && (frame_start || m_state != M_IDLE)) begin
        if (line_len == 0) begin n_err = 1; nxt = M_WAIT; end
        else begin nxt = M_ACTIVE; m_len = int'(line_len); m_idx = 0; end
      end
      m_state = nxt;
      e_done  = complete ? 1 : 0;
      e_err   = n_err ? 1 : 0;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge sensor_clk); #1; end
  endtask

  task automatic frame(input logic [SCHEME_W-1:0] s);
    comp_scheme_in = s; frame_start = 1'b1; cyc(); frame_start = 1'b0;
  endtask

  task automatic start_line(input int len);
    line_len = LEN_W'(len); line_start = 1'b1; cyc(); line_start = 1'b0;
  endtask

  task automatic send(input int n, input bit toggle);
    int sent = 0, guard = 0;
    bus.pix_valid = 1'b1;
    while (sent < n && guard < 200) begin
      bus.out_ready = toggle ? ~bus.out_ready : 1'b1;
      #1;
      if (bus.pix_ready) sent++;
      cyc();
      guard++;
    end
    chk("send_budget", sent, n);
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b1;
    clr_counts();
    cyc(3);
    chk("rst_pix_ready", int'(bus.pix_ready), 0);
    chk("rst_scheme", int'(bus.comp_scheme), 0);
    chk("rst_done_err", int'({line_done, line_err}), 0);
    sys_rst_n = 1'b1;
    cyc(2);

    // Full compressed line, back-to-back
    frame(5'h08); start_line(6); clr_counts();
    send(6, 1'b0); cyc(2);
    chk("l1_enable_cnt", c_en, 6);
    for (int i = 0; i < 4; i++) begin
      chk("l1_pixN_cnt", c_p[i], 1);
      chk("l1_pixN_at", at_p[i], i + 1);
    end
    chk("l1_done", c_done, 1);
    chk("l1_err", c_err, 0);

    // Stalls every other cycle
    start_line(6); clr_counts();
    send(6, 1'b1); cyc(2);
    chk("l2_xfer", c_xfer, 6);
    chk("l2_enable_cnt", c_en, 6);
    chk("l2_pix4_at", at_p[3], 4);
    chk("l2_done", c_done, 1);
    chk("l2_err", c_err, 0);

    // Short line aborted by line_end, then a clean restart
    start_line(8); clr_counts();
    send(3, 1'b0);
    line_end = 1'b1; cyc(); line_end = 1'b0;
    cyc(2);
    chk("l3_err", c_err, 1);
    chk("l3_done", c_done, 0);
    chk("l3_ready_after", int'(bus.pix_ready), 0);
    start_line(8); clr_counts();
    send(1, 1'b0);
    chk("l3_restart_pix1", c_p[0], 1);
    chk("l3_restart_pix1_at", at_p[0], 1);
    line_end = 1'b1; cyc(); line_end = 1'b0; cyc(2);

    // Scheme only moves on frame_start
    start_line(4); comp_scheme_in = 5'h02;
    send(4, 1'b0); cyc();
    chk("l4_scheme_held", int'(bus.comp_scheme), 8);
    frame(5'h02);
    chk("l4_scheme_new", int'(bus.comp_scheme), 2);

    // Uncompressed frame
    frame(5'h00); start_line(4); clr_counts();
    send(4, 1'b0); cyc(2);
    chk("l5_xfer", c_xfer, 4);
    chk("l5_enable", c_en, 0);
    chk("l5_pix_any", c_p[0] + c_p[1] + c_p[2] + c_p[3], 0);
    chk("l5_done", c_done, 1);

    // Zero-length line, then line_end coincident with the last pixel
    frame(5'h08); clr_counts();
    start_line(0); cyc(2);
    chk("l6_zero_err", c_err, 1);
    chk("l6_zero_ready", int'(bus.pix_ready), 0);
    start_line(3); send(2, 1'b0);
    bus.pix_valid = 1'b1; line_end = 1'b1; cyc();
    bus.pix_valid = 1'b0; line_end = 1'b0; cyc(2);
    chk("l6_end_coincide_err", c_err, 1);
    chk("l6_end_coincide_done", c_done, 1);

    // Reset mid-line
    start_line(8); send(2, 1'b0);
    bus.pix_valid = 1'b1;
    sys_rst_n = 1'b0; #1;
    chk("rst_mid_ready", int'(bus.pix_ready), 0);
    chk("rst_mid_enable", int'(bus.enable), 0);
    chk("rst_mid_scheme", int'(bus.comp_scheme), 0);
    cyc(2); sys_rst_n = 1'b1; cyc(); clr_counts();
    start_line(4); cyc(3);
    chk("rst_ignore_line", c_xfer, 0);
    bus.pix_valid = 1'b0;
    frame(5'h08); start_line(4); clr_counts();
    send(4, 1'b0); cyc(2);
    chk("rst_after_done", c_done, 1);
    chk("rst_after_pix1_at", at_p[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
